// File: rtl/disp_conv_sched.sv
// disp_conv_sched
// Round-robin scheduler that shares one combinational binary-to-BCD converter
// among the hours, minutes and seconds fields of the digital clock, and holds
// the six BCD digits that feed the 7-segment decoders.
//
// Optional build macro: DISP_SCHED_BLINK_EN adds blink masking of whole fields.
//
// Ports:
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   req[2:0]            level conversion request, [2]=hours [1]=minutes [0]=seconds
//   bin_hr/min/sec      binary value per field, stable while its req is high
//   ack[2:0]            one-cycle pulse when that field's result is captured
//   conv_bin            registered input to the shared converter
//   conv_tens/ones      converter result (combinational from conv_bin)
//   hr_t .. sec_o       BCD digit outputs (4'hF shows blank)
//   range_err[2:0]      sticky: last captured value of the field was above 99
//   blink[2:0]          per-field blink enable (blink build only)
//   busy                high whenever the FSM is not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; grants the round-robin winner
// ISSUE   | conv_bin held so the converter output settles
// CAPTURE | converter result written to the winner's digits, ack high

module disp_conv_sched #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic [7:0] bin_hr,
  input  logic [7:0] bin_min,
  input  logic [7:0] bin_sec,
  output logic [2:0] ack,
  output logic [7:0] conv_bin,
  input  logic [3:0] conv_tens,
  input  logic [3:0] conv_ones,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [2:0] range_err,
  input  logic [2:0] blink,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0] state;
  logic [1:0] ptr;       // field with highest priority for the next grant
  logic [1:0] win_q;     // field currently being converted
  logic [1:0] win;
  logic [7:0] win_bin;
  logic [3:0] hr_t_q, hr_o_q, min_t_q, min_o_q, sec_t_q, sec_o_q;
  logic [3:0] cap_t, cap_o;
  logic       cap_err;

  // Walk from lowest to highest priority so the highest-priority requester
  // is the last one written.
  always_comb begin
    win = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % 3]) win = 2'((int'(ptr) + i) % 3);
    end
  end

  always_comb begin
    case (win)
      2'd2:    win_bin = bin_hr;
      2'd1:    win_bin = bin_min;
      default: win_bin = bin_sec;
    endcase
  end

  // Out-of-range values blank both digits instead of showing converter junk.
  always_comb begin
    cap_err = (conv_bin > 8'd99);
    cap_t   = cap_err ? 4'hF : conv_tens;
    cap_o   = cap_err ? 4'hF : conv_ones;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      win_q     <= 2'd0;
      conv_bin  <= 8'd0;
      ack       <= 3'b000;
      range_err <= 3'b000;
      hr_t_q    <= 4'd0;
      hr_o_q    <= 4'd0;
      min_t_q   <= 4'd0;
      min_o_q   <= 4'd0;
      sec_t_q   <= 4'd0;
      sec_o_q   <= 4'd0;
    end else begin
      ack <= 3'b000;
      case (state)
        S_IDLE: begin
          if (|req) begin
            conv_bin <= win_bin;
            win_q    <= win;
            ptr      <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ack   <= 3'b001 << win_q;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          range_err[win_q] <= cap_err;
          case (win_q)
            2'd2: begin
              hr_t_q <= cap_t;
              hr_o_q <= cap_o;
            end
            2'd1: begin
              min_t_q <= cap_t;
              min_o_q <= cap_o;
            end
            default: begin
              sec_t_q <= cap_t;
              sec_o_q <= cap_o;
            end
          endcase
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

`ifdef DISP_SCHED_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Masking acts on the outputs only; held digit registers keep their value.
  always_comb begin
    hr_t  = (blink[2] && phase) ? 4'hF : hr_t_q;
    hr_o  = (blink[2] && phase) ? 4'hF : hr_o_q;
    min_t = (blink[1] && phase) ? 4'hF : min_t_q;
    min_o = (blink[1] && phase) ? 4'hF : min_o_q;
    sec_t = (blink[0] && phase) ? 4'hF : sec_t_q;
    sec_o = (blink[0] && phase) ? 4'hF : sec_o_q;
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{blink, (BLINK_DIV > 0)};

  always_comb begin
    hr_t  = hr_t_q;
    hr_o  = hr_o_q;
    min_t = min_t_q;
    min_o = min_o_q;
    sec_t = sec_t_q;
    sec_o = sec_o_q;
  end
`endif

endmodule

// File: tb/tb_disp_conv_sched.sv
module tb_disp_conv_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] req, blink, ack, range_err;
  logic [7:0] bin_hr, bin_min, bin_sec, conv_bin;
  logic [3:0] conv_tens, conv_ones;
  logic [3:0] hr_t, hr_o, min_t, min_o, sec_t, sec_o;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model: expected digits/errors per field, [0]=sec [1]=min [2]=hr
  int         et[3];
  int         eo[3];
  logic [2:0] eerr;
  int         ptr_m;

  disp_conv_sched #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .bin_hr(bin_hr), .bin_min(bin_min), .bin_sec(bin_sec),
    .ack(ack), .conv_bin(conv_bin), .conv_tens(conv_tens), .conv_ones(conv_ones),
    .hr_t(hr_t), .hr_o(hr_o), .min_t(min_t), .min_o(min_o),
    .sec_t(sec_t), .sec_o(sec_o), .range_err(range_err),
    .blink(blink), .busy(busy)
  );

  // behavioural stand-in for the shared combinational converter
  assign conv_tens = 4'((conv_bin / 8'd10) % 8'd10);
  assign conv_ones = 4'(conv_bin % 8'd10);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      et[k] = 0;
      eo[k] = 0;
    end
    eerr  = 3'b000;
    ptr_m = 0;
  endtask

  task automatic model_capture(input int f, input int v);
    if (v <= 99) begin
      et[f] = v / 10;
      eo[f] = v % 10;
      eerr[f] = 1'b0;
    end else begin
      et[f] = 15;
      eo[f] = 15;
      eerr[f] = 1'b1;
    end
  endtask

  task automatic chk_display();
    chk("hr_digits",  {8'h00, hr_t,  hr_o},  16'((et[2] << 4) | eo[2]));
    chk("min_digits", {8'h00, min_t, min_o}, 16'((et[1] << 4) | eo[1]));
    chk("sec_digits", {8'h00, sec_t, sec_o}, 16'((et[0] << 4) | eo[0]));
    chk("range_err",  {13'h0, range_err},    {13'h0, eerr});
  endtask

  // Applies a request mask held until each field's ack; the model predicts
  // the grant order from the pointer and checks every conversion.
  task automatic run_batch(input logic [2:0] mask, input logic [7:0] h,
                           input logic [7:0] m, input logic [7:0] s);
    int v[3];
    int order[$];
    v[0] = int'(s);
    v[1] = int'(m);
    v[2] = int'(h);
    bin_hr  = h;
    bin_min = m;
    bin_sec = s;
    req     = mask;
    for (int k = 0; k < 3; k++) begin
      if (mask[(ptr_m + k) % 3]) order.push_back((ptr_m + k) % 3);
    end
    foreach (order[i]) begin
      int f;
      f = order[i];
      step();
      chk("conv_bin_grant", {8'h00, conv_bin}, 16'(v[f]));
      chk("busy_issue", {15'h0, busy}, 16'd1);
      chk("ack_issue", {13'h0, ack}, 16'd0);
      step();
      chk("ack_capture", {13'h0, ack}, 16'(1 << f));
      req[f] = 1'b0;
      step();
      model_capture(f, v[f]);
      ptr_m = (f + 1) % 3;
      chk("ack_after", {13'h0, ack}, 16'd0);
      chk("busy_idle", {15'h0, busy}, 16'd0);
      chk_display();
    end
  endtask

  initial begin
    logic [7:0] h, cur;
    int         nblank;
    logic       bl[16];

    reset_n = 1'b0;
    req     = 3'b000;
    blink   = 3'b000;
    bin_hr  = 8'd0;
    bin_min = 8'd0;
    bin_sec = 8'd0;
    model_reset();
    #2;
    chk("rst_ack", {13'h0, ack}, 16'd0);
    chk("rst_busy", {15'h0, busy}, 16'd0);
    chk("rst_conv_bin", {8'h00, conv_bin}, 16'd0);
    chk_display();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("idle_ack", {13'h0, ack}, 16'd0);
      chk("idle_busy", {15'h0, busy}, 16'd0);
    end

    // single seconds request
    run_batch(3'b001, 8'd0, 8'd0, 8'd47);
    chk("sec_47", {8'h00, sec_t, sec_o}, 16'h0047);

    // reset asserted during ISSUE aborts the conversion
    run_batch(3'b110, 8'd8, 8'd31, 8'd0);
    bin_sec = 8'd33;
    req     = 3'b001;
    step();
    chk("pre_rst_busy", {15'h0, busy}, 16'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ack", {13'h0, ack}, 16'd0);
    chk("midrst_busy", {15'h0, busy}, 16'd0);
    chk("midrst_conv_bin", {8'h00, conv_bin}, 16'd0);
    chk_display();
    req = 3'b000;
    step();
    chk("inrst_ack", {13'h0, ack}, 16'd0);
    reset_n = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_ack", {13'h0, ack}, 16'd0);
      chk("post_rst_busy", {15'h0, busy}, 16'd0);
    end
    chk_display();

    // simultaneous requests, pointer back at seconds
    run_batch(3'b111, 8'd23, 8'd59, 8'd5);
    chk("hms_final", {hr_t, hr_o, min_t, min_o}, 16'h2359);

    // range error and boundaries
    run_batch(3'b010, 8'd0, 8'd100, 8'd0);
    run_batch(3'b010, 8'd0, 8'd99, 8'd0);
    run_batch(3'b001, 8'd0, 8'd0, 8'd255);
    run_batch(3'b001, 8'd0, 8'd0, 8'd0);
    run_batch(3'b100, 8'd255, 8'd0, 8'd0);
    run_batch(3'b101, 8'd99, 8'd0, 8'd100);

    // hours request held for 9 cycles, bin_hr changed during each ISSUE
    h       = 8'd17;
    bin_hr  = h;
    req     = 3'b100;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("held_conv_bin", {8'h00, conv_bin}, {8'h00, h});
      cur    = h;
      bin_hr = 8'((int'(h) + 1 + $urandom_range(0, 50)) % 100);
      step();
      chk("held_ack", {13'h0, ack}, 16'h0004);
      chk("held_conv_stable", {8'h00, conv_bin}, {8'h00, cur});
      if (r == 2) req = 3'b000;
      step();
      model_capture(2, int'(cur));
      chk("held_conv_stable2", {8'h00, conv_bin}, {8'h00, cur});
      chk_display();
      h = bin_hr;
    end
    ptr_m = 0;
    step();
    chk("held_done_busy", {15'h0, busy}, 16'd0);

    // randomized batches
    for (int n = 0; n < 30; n++) begin
      logic [7:0] rv[3];
      for (int k = 0; k < 3; k++) begin
        rv[k] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(100, 255))
                                             : 8'($urandom_range(0, 99));
      end
      run_batch(3'($urandom_range(1, 7)), rv[2], rv[1], rv[0]);
    end

    run_batch(3'b111, 8'd12, 8'd34, 8'd56);
`ifdef DISP_SCHED_BLINK_EN
    blink  = 3'b100;
    nblank = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      bl[i] = (hr_t == 4'hF) && (hr_o == 4'hF);
      if (bl[i]) nblank++;
      else chk("blink_hr_shown", {8'h00, hr_t, hr_o}, 16'h0012);
      chk("blink_min_steady", {8'h00, min_t, min_o}, 16'h0034);
      chk("blink_sec_steady", {8'h00, sec_t, sec_o}, 16'h0056);
    end
    chk("blink_count", 16'(nblank), 16'd8);
    for (int i = 4; i < 16; i++) chk("blink_period", {15'h0, bl[i] ^ bl[i-4]}, 16'd1);
    blink = 3'b000;
    step();
    chk_display();
`else
    blink  = 3'b111;
    nblank = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      bl[i] = 1'b0;
      chk_display();
    end
    blink = 3'b000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_conv_sched.md
# disp_conv_sched

Round-robin scheduler that shares one combinational 8-bit binary-to-BCD converter among the three time fields of the digital clock: hours, minutes and seconds. Each field requests a conversion with a level req / one-cycle ack handshake. The block drives the converter input from a register, captures its tens/ones result, and holds six BCD digit registers that feed the 7-segment decoders. Optional blink masking hides a field's digits during time setting.

## Interface
Parameters:
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; used only with DISP_SCHED_BLINK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  3  conversion request per field; [2]=hours, [1]=minutes, [0]=seconds.
- bin_hr, bin_min, bin_sec  in  8 each  binary value per field; must stay stable while the matching req is high.
- ack  out  3  one-cycle pulse per field, asserted when that field's result is captured.
- conv_bin  out  8  registered input to the shared converter.
- conv_tens, conv_ones  in  4 each  converter result, combinational from conv_bin.
- hr_t, hr_o, min_t, min_o, sec_t, sec_o  out  4 each  held BCD digits.
- range_err  out  3  sticky per-field flag: the last captured value was above 99.
- blink  in  3  per-field blink enable; used only with DISP_SCHED_BLINK_EN.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: if any req bit is high, pick the winner by round-robin, register the winner's bin into conv_bin, store the winner index, go to ISSUE.
  - ISSUE: hold conv_bin so the converter settles; go to CAPTURE.
  - CAPTURE: if conv_bin <= 99, load conv_tens/conv_ones into the winner's digit pair and clear its range_err bit. Otherwise load 4'hF into both digits (the decoders show 4'hF as blank) and set its range_err bit. Pulse ack[winner]. Return to IDLE.
- Round-robin:
  - The priority pointer starts after the last granted field. Order is seconds -> minutes -> hours -> seconds.
  - After reset the pointer favours seconds first.
  - The pointer updates only on a grant.
- A req still high in the cycle after its ack counts as a new request.
- A req that drops before its grant is ignored: no ack, digits unchanged.
- A req that drops after its grant has no effect. The conversion completes and ack still pulses.
- A change on bin_* after the grant has no effect, because conv_bin is already registered.
- Non-granted requests stay pending; a req is never lost while held.
- conv_bin changes only on the IDLE->ISSUE transition.

## Timing
- Reset values (asynchronous, while reset_n is low):
  - state IDLE, ack 0, busy 0, conv_bin 0.
  - All digit outputs 0 (display shows 00:00:00).
  - range_err 0, priority pointer at seconds.
- Reset asserted mid-conversion aborts it: no ack, digits hold their reset values.
- Latency, with req sampled high in IDLE at edge N:
  - conv_bin valid and state ISSUE after edge N.
  - CAPTURE after edge N+1; ack is high during this cycle.
  - Digits updated after edge N+2.
- Throughput is one conversion per 3 cycles.
- Three simultaneous requests complete within 9 cycles, in pointer order.
- Boundary values: 0 -> 0/0; 99 -> 9/9 with no error; 100 and 255 -> F/F with the error bit set.

## Configuration
- DISP_SCHED_BLINK_EN defined:
  - A BLINK_DIV counter toggles a phase bit.
  - While blink[k]=1 and phase=1, field k's digit outputs read 4'hF. The held digit registers are unchanged.
  - The counter and phase reset to 0.
- DISP_SCHED_BLINK_EN undefined:
  - The blink input is ignored and no counter is built.
  - Digit outputs are the held registers directly.

## Test plan
- Reset: hold reset_n low mid-ISSUE -> ack=0, busy=0, all digits 0, range_err=0; release and idle -> no activity.
- Single request: req=3'b001 with bin_sec=8'd47 -> conv_bin=47 one cycle later, ack=3'b001 two cycles later, sec_t=4 and sec_o=7 after that edge.
- Simultaneous requests: req=3'b111 held until each ack, with hr=23, min=59, sec=5 -> acks in order sec, min, hr at 3-cycle spacing; final digits 23/59/05.
- Range error: bin_min=8'd100 -> min_t=min_o=4'hF and range_err[1]=1; a later bin_min=8'd99 -> 9/9 and range_err[1]=0.
- Held req: req[2] held for 9 cycles with no competitors -> ack[2] pulses every 3 cycles, conv_bin is stable outside IDLE->ISSUE, and changing bin_hr during ISSUE does not alter that result.
- Blink (macro defined, BLINK_DIV=4): blink=3'b100 with hr=12 -> hr_t/hr_o alternate 1/2 and F/F every 4 cycles while the minute and second digits stay steady.
